// File: rtl/pipe_ctl.sv
`timescale 1ns/1ps
// pipe_ctl: IF-stage decode, lockstep ID/EX/MEM/WB control flags and the IF stall unit of a 5-stage MIPS core.
// Define PIPE_FWD_EN to build the EX-stage forwarding unit; without it every pending RAW hazard stalls IF.
module pipe_ctl #(
  parameter int BR_BUBBLES = 1,
  parameter int RA_W       = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ins,
  output logic        f_choke,
  output logic        f_jmp,
  output logic        f_branch,
  output logic        f_rd,
  output logic        f_alus,
  output logic        f_aluo,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        f_mw,
  output logic        f_rw,
  output logic        f_m2r
);
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [1:0] BB      = 2'(BR_BUBBLES);

  typedef logic [RA_W-1:0] ra_t;
  typedef struct packed { logic rd, branch, alus, aluo, mw, rw, m2r; ra_t rs, rt, wa; } id_t;
  typedef struct packed { logic alus, aluo, mw, rw, m2r; ra_t rs, rt, wa; } ex_t;
  typedef struct packed { logic mw, rw, m2r; ra_t wa; } mem_t;
  typedef struct packed { logic rw, m2r; ra_t wa; } wb_t;

  id_t        dec, id;
  ex_t        ex;
  mem_t       mem;
  wb_t        wb;
  logic       rd_rs, rd_rt, is_j;
  logic       ld_use, raw_stall, br_stall;
  logic [1:0] bcnt;
  logic       unused_ins;

  assign unused_ins = ^ins[10:0];

  always_comb begin
    dec    = '0;
    rd_rs  = 1'b0;
    rd_rt  = 1'b0;
    is_j   = 1'b0;
    dec.rs = RA_W'(ins[25:21]);
    dec.rt = RA_W'(ins[20:16]);
    dec.wa = (ins[31:26] == OP_R) ? RA_W'(ins[15:11]) : RA_W'(ins[20:16]);
    case (ins[31:26])
      OP_R:    begin dec.rd = 1'b1; dec.rw = 1'b1; rd_rs = 1'b1; rd_rt = 1'b1; end
      OP_ADDI: begin dec.alus = 1'b1; dec.rw = 1'b1; rd_rs = 1'b1; end
      OP_LW:   begin dec.alus = 1'b1; dec.rw = 1'b1; dec.m2r = 1'b1; rd_rs = 1'b1; end
      OP_SW:   begin dec.alus = 1'b1; dec.mw = 1'b1; rd_rs = 1'b1; rd_rt = 1'b1; end
      OP_BEQ:  begin dec.branch = 1'b1; dec.aluo = 1'b1; rd_rs = 1'b1; rd_rt = 1'b1; end
      OP_J:    is_j = 1'b1;
      default: ;
    endcase
  end

  // bcnt != 0 covers both the cycle the beq sits in ID and the trailing bubbles.
  assign br_stall = (bcnt != 2'd0);
  assign ld_use   = id.m2r && (id.wa != '0) &&
                    ((rd_rs && dec.rs == id.wa) || (rd_rt && dec.rt == id.wa));

`ifdef PIPE_FWD_EN
  function automatic logic [1:0] fsel(input ra_t r, input logic m_rw, input ra_t m_wa,
                                      input logic w_rw, input ra_t w_wa);
    if (m_rw && m_wa != '0 && m_wa == r)      return 2'b01;
    else if (w_rw && w_wa != '0 && w_wa == r) return 2'b10;
    else                                      return 2'b00;
  endfunction

  assign raw_stall = 1'b0;
  assign fwd_a     = fsel(ex.rs, mem.rw, mem.wa, wb.rw, wb.wa);
  assign fwd_b     = fsel(ex.rt, mem.rw, mem.wa, wb.rw, wb.wa);
`else
  logic unused_fwd;

  // WB is left out: the register file writes in the first half-cycle.
  function automatic logic pend(input ra_t r, input logic i_rw, input ra_t i_wa,
                                input logic e_rw, input ra_t e_wa, input logic m_rw, input ra_t m_wa);
    return (r != '0) && ((i_rw && i_wa == r) || (e_rw && e_wa == r) || (m_rw && m_wa == r));
  endfunction

  assign raw_stall  = (rd_rs && pend(dec.rs, id.rw, id.wa, ex.rw, ex.wa, mem.rw, mem.wa)) ||
                      (rd_rt && pend(dec.rt, id.rw, id.wa, ex.rw, ex.wa, mem.rw, mem.wa));
  assign fwd_a      = 2'b00;
  assign fwd_b      = 2'b00;
  assign unused_fwd = ^{ex.rs, ex.rt, wb.wa};
`endif

  assign f_choke  = br_stall | ld_use | raw_stall;
  assign f_jmp    = is_j & ~f_choke;
  assign f_branch = id.branch;
  assign f_rd     = id.rd;
  assign f_alus   = ex.alus;
  assign f_aluo   = ex.aluo;
  assign f_mw     = mem.mw;
  assign f_rw     = wb.rw;
  assign f_m2r    = wb.m2r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt <= 2'd0;
    end else if (f_choke) begin
      if (br_stall) bcnt <= bcnt - 2'd1;
    end else if (dec.branch) begin
      bcnt <= BB;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id  <= '0;
      ex  <= '0;
      mem <= '0;
      wb  <= '0;
    end else begin
      id  <= f_choke ? id_t'('0) : dec;
      ex  <= '{alus: id.alus, aluo: id.aluo, mw: id.mw, rw: id.rw, m2r: id.m2r,
               rs: id.rs, rt: id.rt, wa: id.wa};
      mem <= '{mw: ex.mw, rw: ex.rw, m2r: ex.m2r, wa: ex.wa};
      wb  <= '{rw: mem.rw, m2r: mem.m2r, wa: mem.wa};
    end
  end
endmodule
